status_input_buffer: RTL and testbench
======================================

STATUS_INPUT_BUFFER -- requirements
Module: status_input_buffer

Interface
REQ-001 The block SHALL provide port ck, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL provide port floor, input, 4 bits: current car floor, 1-based; valid range 1..8.
REQ-004 The block SHALL provide port openflag, input, 1 bit: door is opening or open at the current floor.
REQ-005 The block SHALL provide port elevator_status, input, 4 bits: bit0 = moving/committed up, bit1 = moving/committed down; bits 3:2 are ignored.
REQ-006 The block SHALL provide port upcall_input, input, 8 bits: hall up-call buttons; bit k = floor k+1.
REQ-007 The block SHALL provide port downcall_input, input, 8 bits: hall down-call buttons; bit k = floor k+1.
REQ-008 The block SHALL provide port floor_btn_input, input, 8 bits: in-car floor buttons; bit k = floor k+1.
REQ-009 The block SHALL provide port upcall, output, 8 bits: latched pending up-calls.
REQ-010 The block SHALL provide port downcall, output, 8 bits: latched pending down-calls.
REQ-011 The block SHALL provide port floor_btn, output, 8 bits: latched pending car calls.
REQ-012 Every output SHALL be driven directly from a register.

Function
REQ-013 The block SHALL keep a registered copy of each of the three input vectors, to detect a press as a rising edge (input 1 now, 0 last cycle).
REQ-014 A rising edge on a bit SHALL set the matching latched bit on the next ck edge.
REQ-015 A held input SHALL NOT set the bit again after it has been cleared.
REQ-016 upcall[7] and downcall[0] SHALL always read 0; presses on those bits are ignored.
REQ-017 Clear condition: openflag=1 and floor is in 1..8; the target index is i = floor-1.
REQ-018 Under the clear condition, floor_btn[i] SHALL clear.
REQ-019 Under the clear condition, upcall[i] SHALL clear when elevator_status[0]=1 or when elevator_status[1:0]=00.
REQ-020 Under the clear condition, downcall[i] SHALL clear when elevator_status[1]=1 or when elevator_status[1:0]=00.
REQ-021 If elevator_status[1:0]=11, the block SHALL treat the car as idle (00).
REQ-022 When floor is 0 or greater than 8, no bit SHALL clear.
REQ-023 When a set and a clear hit the same bit in the same cycle, the clear SHALL win: the bit stays 0 and the press is consumed.
REQ-024 Bits other than index i SHALL be unaffected by a clear.
REQ-025 Presses on other floors in the same cycle as a clear SHALL latch normally.
REQ-026 Latency: a press appears on the output 2 ck edges after the input rises (1 edge to register the input, 1 edge to set the bit); a clear takes effect 1 ck edge after the clear condition.

Reset
REQ-027 While rst=1 at a ck edge, upcall, downcall, floor_btn and all edge-history registers SHALL become 0.
REQ-028 A press arriving during reset SHALL be discarded.
REQ-029 The first cycle after reset SHALL treat history as 0, so an input already held high latches once.

Configuration
REQ-030 Macro FLOOR_BTN_CANCEL_EN defined: a rising edge on floor_btn_input[k] while floor_btn[k]=1 SHALL clear floor_btn[k] (toggle cancel).
REQ-031 Macro FLOOR_BTN_CANCEL_EN defined: hall calls SHALL keep set-only behaviour.
REQ-032 Macro FLOOR_BTN_CANCEL_EN undefined: a press on an already-latched bit SHALL have no effect.

Verification
REQ-033 Reset, then pulse floor_btn_input[5] for 1 cycle -> floor_btn=8'h20 two edges later and held after the input drops.
REQ-034 upcall=8'h08, downcall=8'h08, floor=4, openflag=1, elevator_status=4'b0001 -> upcall=8'h00, downcall=8'h08.
REQ-035 Same latched state as REQ-034 with elevator_status=4'b0000 -> both calls at floor 4 cleared.
REQ-036 Press upcall_input[7] and downcall_input[0] -> upcall[7]=0 and downcall[0]=0; press upcall_input[6] -> upcall=8'h40.
REQ-037 Hold floor_btn_input[2] high while floor=3 and openflag=1 -> floor_btn[2] stays 0, including after openflag drops.
REQ-038 With FLOOR_BTN_CANCEL_EN defined, two separate presses of floor_btn_input[1] -> floor_btn[1] goes 1 then 0.
REQ-039 Assert rst with floor_btn=8'hFF -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/status_input_buffer.sv
// Hall/car call latch for an 8-floor elevator: edge-detected presses set pending bits,
// door-open at a floor clears them. Define FLOOR_BTN_CANCEL_EN for toggle-cancel of car calls.
module status_input_buffer (
    input  logic       ck,
    input  logic       rst,
    input  logic [3:0] floor,
    input  logic       openflag,
    input  logic [3:0] elevator_status,
    input  logic [7:0] upcall_input,
    input  logic [7:0] downcall_input,
    input  logic [7:0] floor_btn_input,
    output logic [7:0] upcall,
    output logic [7:0] downcall,
    output logic [7:0] floor_btn
);

    // Top floor has no up-call, bottom floor has no down-call.
    localparam logic [7:0] UP_MASK = 8'h7F;
    localparam logic [7:0] DN_MASK = 8'hFE;

    logic [7:0] up_in_r, dn_in_r, fb_in_r;
    logic [7:0] up_prev_r, dn_prev_r, fb_prev_r;
    logic [7:0] up_rise_s, dn_rise_s, fb_rise_s;
    logic [7:0] clr_onehot_s;
    logic       up_clr_en_s, dn_clr_en_s;
    logic [7:0] upcall_nxt_s, downcall_nxt_s, floor_btn_nxt_s;

    // Press detection on the registered inputs.
    always_comb begin
        up_rise_s = up_in_r & ~up_prev_r;
        dn_rise_s = dn_in_r & ~dn_prev_r;
        fb_rise_s = fb_in_r & ~fb_prev_r;
    end

    // Which hall-call directions are served by a stop; 2'b11 is treated as idle.
    always_comb begin
        up_clr_en_s = 1'b0;
        dn_clr_en_s = 1'b0;
        case (elevator_status[1:0])
            2'b01: begin
                up_clr_en_s = 1'b1;
                dn_clr_en_s = 1'b0;
            end
            2'b10: begin
                up_clr_en_s = 1'b0;
                dn_clr_en_s = 1'b1;
            end
            2'b00, 2'b11: begin
                up_clr_en_s = 1'b1;
                dn_clr_en_s = 1'b1;
            end
            default: begin
                up_clr_en_s = 1'b1;
                dn_clr_en_s = 1'b1;
            end
        endcase
    end

    // One-hot clear target; out-of-range floors clear nothing.
    always_comb begin
        clr_onehot_s = 8'h00;
        if (openflag && (floor >= 4'd1) && (floor <= 4'd8)) begin
            clr_onehot_s = 8'h01 << (floor - 4'd1);
        end else begin
            clr_onehot_s = 8'h00;
        end
    end

    // Next latched state; clear dominates a coincident press.
    always_comb begin
        upcall_nxt_s   = (upcall | up_rise_s) & ~(clr_onehot_s & {8{up_clr_en_s}}) & UP_MASK;
        downcall_nxt_s = (downcall | dn_rise_s) & ~(clr_onehot_s & {8{dn_clr_en_s}}) & DN_MASK;
`ifdef FLOOR_BTN_CANCEL_EN
        floor_btn_nxt_s = (floor_btn ^ fb_rise_s) & ~clr_onehot_s;
`else
        floor_btn_nxt_s = (floor_btn | fb_rise_s) & ~clr_onehot_s;
`endif
    end

    // Input history and latched call registers.
    always_ff @(posedge ck) begin
        if (rst) begin
            up_in_r   <= 8'h00;
            dn_in_r   <= 8'h00;
            fb_in_r   <= 8'h00;
            up_prev_r <= 8'h00;
            dn_prev_r <= 8'h00;
            fb_prev_r <= 8'h00;
            upcall    <= 8'h00;
            downcall  <= 8'h00;
            floor_btn <= 8'h00;
        end else begin
            up_in_r   <= upcall_input;
            dn_in_r   <= downcall_input;
            fb_in_r   <= floor_btn_input;
            up_prev_r <= up_in_r;
            dn_prev_r <= dn_in_r;
            fb_prev_r <= fb_in_r;
            upcall    <= upcall_nxt_s;
            downcall  <= downcall_nxt_s;
            floor_btn <= floor_btn_nxt_s;
        end
    end

endmodule

// File: tb/tb_status_input_buffer.sv
// Self-checking bench for status_input_buffer: directed scenarios then random traffic,
// checked against a per-floor reference model built from input sample history.
module tb_status_input_buffer;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] floor = 4'd0;
    logic       openflag = 1'b0;
    logic [3:0] elevator_status = 4'd0;
    logic [7:0] upcall_input = 8'h00;
    logic [7:0] downcall_input = 8'h00;
    logic [7:0] floor_btn_input = 8'h00;
    logic [7:0] upcall, downcall, floor_btn;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_up = 8'h00, m_dn = 8'h00, m_fb = 8'h00;
    logic [7:0] hu[$], hd[$], hf[$];

    status_input_buffer dut (
        .ck(ck), .rst(rst), .floor(floor), .openflag(openflag),
        .elevator_status(elevator_status), .upcall_input(upcall_input),
        .downcall_input(downcall_input), .floor_btn_input(floor_btn_input),
        .upcall(upcall), .downcall(downcall), .floor_btn(floor_btn)
    );

    always #5 ck = ~ck;

    // A press is an input bit seen high at the previous edge and low at the one before.
    function automatic logic [7:0] press_of(input logic [7:0] newer, input logic [7:0] older);
        return newer & ~older;
    endfunction

    task automatic model_edge();
        logic [7:0] pu, pd, pf;
        int tgt;
        bit going_up, going_down;
        if (rst) begin
            m_up = 8'h00; m_dn = 8'h00; m_fb = 8'h00;
            hu.delete(); hd.delete(); hf.delete();
            return;
        end
        pu = press_of(hu.size() > 0 ? hu[$] : 8'h00, hu.size() > 1 ? hu[$-1] : 8'h00);
        pd = press_of(hd.size() > 0 ? hd[$] : 8'h00, hd.size() > 1 ? hd[$-1] : 8'h00);
        pf = press_of(hf.size() > 0 ? hf[$] : 8'h00, hf.size() > 1 ? hf[$-1] : 8'h00);
        tgt = (openflag && floor >= 4'd1 && floor <= 4'd8) ? int'(floor) - 1 : -1;
        going_up   = elevator_status[0] && !elevator_status[1];
        going_down = elevator_status[1] && !elevator_status[0];
        for (int k = 0; k < 8; k++) begin
            if (pu[k] && k != 7) m_up[k] = 1'b1;
            if (pd[k] && k != 0) m_dn[k] = 1'b1;
`ifdef FLOOR_BTN_CANCEL_EN
            if (pf[k]) m_fb[k] = !m_fb[k];
`else
            if (pf[k]) m_fb[k] = 1'b1;
`endif
            if (k == tgt) begin
                if (!going_down) m_up[k] = 1'b0;
                if (!going_up)   m_dn[k] = 1'b0;
                m_fb[k] = 1'b0;
            end
        end
        hu.push_back(upcall_input);
        hd.push_back(downcall_input);
        hf.push_back(floor_btn_input);
        if (hu.size() > 2) void'(hu.pop_front());
        if (hd.size() > 2) void'(hd.pop_front());
        if (hf.size() > 2) void'(hf.pop_front());
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        model_edge();
        #1;
        check("upcall", upcall, m_up);
        check("downcall", downcall, m_dn);
        check("floor_btn", floor_btn, m_fb);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("reset_up", upcall, 8'h00);
        check("reset_fb", floor_btn, 8'h00);
        rst = 1'b0;

        // Single-cycle car-call pulse latches two edges later and holds
        floor_btn_input = 8'h20; tick();
        floor_btn_input = 8'h00; tick();
        check("pulse_fb", floor_btn, 8'h20);
        tick();
        check("pulse_fb_held", floor_btn, 8'h20);

        // Latch up/down calls at floor 4, stop going up
        upcall_input = 8'h08; downcall_input = 8'h08; tick();
        upcall_input = 8'h00; downcall_input = 8'h00; tick();
        check("latch_up4", upcall, 8'h08);
        floor = 4'd4; openflag = 1'b1; elevator_status = 4'b0001; tick();
        check("stop_up_up", upcall, 8'h00);
        check("stop_up_dn", downcall, 8'h08);
        check("stop_up_fb", floor_btn, 8'h20);

        // Idle stop clears both directions
        openflag = 1'b0;
        upcall_input = 8'h08; tick();
        upcall_input = 8'h00; tick();
        openflag = 1'b1; elevator_status = 4'b0000; tick();
        check("idle_up", upcall, 8'h00);
        check("idle_dn", downcall, 8'h00);
        openflag = 1'b0;

        // Nonexistent hall buttons ignored
        upcall_input = 8'h80; downcall_input = 8'h01; tick();
        upcall_input = 8'h00; downcall_input = 8'h00; tick();
        check("up7_ignored", upcall, 8'h00);
        check("dn0_ignored", downcall, 8'h00);
        upcall_input = 8'h40; tick();
        upcall_input = 8'h00; tick();
        check("up6", upcall, 8'h40);

        // Held car button at an open door is consumed
        floor = 4'd3; openflag = 1'b1; floor_btn_input = 8'h04;
        repeat (4) tick();
        check("held_open_fb", floor_btn, 8'h20);
        openflag = 1'b0; tick(); tick();
        check("held_closed_fb", floor_btn, 8'h20);
        floor_btn_input = 8'h00; floor = 4'd0; tick();

        // Second press on a latched car call
        floor_btn_input = 8'h02; tick();
        floor_btn_input = 8'h00; tick();
        check("fb1_first", floor_btn, 8'h22);
        floor_btn_input = 8'h02; tick();
        floor_btn_input = 8'h00; tick();
`ifdef FLOOR_BTN_CANCEL_EN
        check("fb1_cancel", floor_btn, 8'h20);
`else
        check("fb1_repress", floor_btn, 8'h22);
`endif

        // Fill car calls, then reset clears everything
        floor_btn_input = ~m_fb; tick();
        floor_btn_input = 8'h00; tick();
        check("fb_full", floor_btn, 8'hFF);
        rst = 1'b1; tick();
        check("rst_fb", floor_btn, 8'h00);
        check("rst_up", upcall, 8'h00);

        // Input held through reset latches once afterwards
        upcall_input = 8'h10; tick();
        rst = 1'b0; tick(); tick();
        check("post_rst_up", upcall, 8'h10);
        upcall_input = 8'h00; tick();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst             = ($urandom_range(0, 59) == 0);
            floor           = 4'($urandom_range(0, 10));
            openflag        = 1'($urandom_range(0, 2) == 0);
            elevator_status = 4'($urandom);
            upcall_input    = 8'($urandom & $urandom);
            downcall_input  = 8'($urandom & $urandom);
            floor_btn_input = 8'($urandom & $urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
